// File: rtl/shift_sequencer_pkg.sv
// Shared types for the shift sequencer: FSM state encoding and direction codes.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake plus the control/feedback bus of the external shift register.
interface shift_sequencer_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned AMT_W = $clog2(N)
) ();

    logic             req_valid;
    logic             req_ready;
    logic [N-1:0]     req_data;
    logic             req_dir;
    logic [AMT_W-1:0] req_amt;
    logic             req_fill;
    logic             req_rotate;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [N-1:0]     rsp_data;

    logic             busy;

    logic [N-1:0]     sr_in;
    logic             sr_enable;
    logic             sr_direction;
    logic             sr_I;
    logic [N-1:0]     sr_out;

    // Requester and shift-register side.
    modport master (
        output req_valid, req_data, req_dir, req_amt, req_fill, req_rotate, rsp_ready, sr_out,
        input  req_ready, rsp_valid, rsp_data, busy, sr_in, sr_enable, sr_direction, sr_I
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_data, req_dir, req_amt, req_fill, req_rotate, rsp_ready, sr_out,
        output req_ready, rsp_valid, rsp_data, busy, sr_in, sr_enable, sr_direction, sr_I
    );

endinterface

// File: rtl/shift_sequencer_step_counter.sv
// Loadable down-counter counting SHIFT cycles; last_o is high while the count equals 1.
module shift_step_counter #(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [AMT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [AMT_W-1:0] count_q, count_d;
    logic             last_q;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - AMT_W'(1);
        end
    end

    // last is registered from the next count so it lines up with count_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == AMT_W'(1));
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller driving a 1-bit-per-cycle shift register: load, AMT shifts, respond.
// Optional rotate support is enabled by defining SHIFT_ROTATE_EN.
module shift_sequencer #(
    parameter int unsigned N     = 16,
    parameter int unsigned AMT_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    shift_sequencer_if.slave bus
);

    import shift_ctrl_pkg::*;

    state_e           state_q, state_d;
    logic [N-1:0]     data_q, data_d;
    logic             dir_q, dir_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             fill_q, fill_d;
`ifdef SHIFT_ROTATE_EN
    logic             rot_q, rot_d;
`else
    logic             unused_rotate;
    assign unused_rotate = bus.req_rotate;
`endif

    logic             req_ready_q, rsp_valid_q, busy_q, sr_enable_q, sr_direction_q;
    logic             cnt_load, cnt_dec, cnt_last;
    logic [N-1:0]     sr_in_c;
    logic             sr_i_c;

    shift_step_counter #(.AMT_W(AMT_W)) u_step_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (amt_q),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    // Next state, request capture and shift-register datapath steering.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        dir_d    = dir_q;
        amt_d    = amt_q;
        fill_d   = fill_q;
`ifdef SHIFT_ROTATE_EN
        rot_d    = rot_q;
`endif
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        sr_in_c  = '0;
        sr_i_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    data_d  = bus.req_data;
                    dir_d   = bus.req_dir;
                    amt_d   = bus.req_amt;
                    fill_d  = bus.req_fill;
`ifdef SHIFT_ROTATE_EN
                    rot_d   = bus.req_rotate;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                sr_in_c  = data_q;
                state_d  = (amt_q != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                cnt_dec = 1'b1;
                sr_in_c = bus.sr_out;
                sr_i_c  = fill_q;
`ifdef SHIFT_ROTATE_EN
                if (rot_q) begin
                    sr_i_c = (dir_q == DIR_LEFT) ? bus.sr_out[N-1] : bus.sr_out[0];
                end
`endif
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sr_in_c = bus.sr_out;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status/control outputs are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            data_q         <= '0;
            dir_q          <= DIR_RIGHT;
            amt_q          <= '0;
            fill_q         <= 1'b0;
`ifdef SHIFT_ROTATE_EN
            rot_q          <= 1'b0;
`endif
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            busy_q         <= 1'b0;
            sr_enable_q    <= 1'b0;
            sr_direction_q <= DIR_RIGHT;
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            dir_q          <= dir_d;
            amt_q          <= amt_d;
            fill_q         <= fill_d;
`ifdef SHIFT_ROTATE_EN
            rot_q          <= rot_d;
`endif
            req_ready_q    <= (state_d == IDLE);
            rsp_valid_q    <= (state_d == DONE);
            busy_q         <= (state_d != IDLE);
            sr_enable_q    <= (state_d == SHIFT);
            sr_direction_q <= (state_d == SHIFT) ? dir_d : DIR_RIGHT;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = bus.sr_out;
    assign bus.busy         = busy_q;
    assign bus.sr_in        = sr_in_c;
    assign bus.sr_enable    = sr_enable_q;
    assign bus.sr_direction = sr_direction_q;
    assign bus.sr_I         = sr_i_c;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 1-bit-per-cycle shift register attached.
module tb_shift_sequencer;

    localparam int unsigned N     = 16;
    localparam int unsigned AMT_W = 4;

    logic clk;
    logic reset;
    logic [N-1:0] sr_q;

    int n_vec;
    int n_err;

    shift_sequencer_if #(.N(N), .AMT_W(AMT_W)) sif ();

    shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shift register: enable shifts serial I in, otherwise loads 'in'.
    always @(posedge clk) begin
        if (!reset) sr_q <= '0;
        else if (sif.sr_enable)
            sr_q <= sif.sr_direction ? {sr_q[N-2:0], sif.sr_I} : {sif.sr_I, sr_q[N-1:1]};
        else
            sr_q <= sif.sr_in;
    end
    assign sif.sr_out = sr_q;

    typedef struct {
        logic [N-1:0]     data;
        logic             dir;
        logic [AMT_W-1:0] amt;
        logic             fill;
        logic             rot;
        logic [N-1:0]     exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int hold);
        int lat;
        int en;
        logic dir_bad;
        sif.req_data   = v.data;
        sif.req_dir    = v.dir;
        sif.req_amt    = v.amt;
        sif.req_fill   = v.fill;
        sif.req_rotate = v.rot;
        sif.req_valid  = 1'b1;
        chk("req_ready_idle", 32'(sif.req_ready), 32'd1);
        lat = 0;
        en = 0;
        dir_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                sif.req_valid  = 1'b0;
                sif.req_data   = ~v.data;
                sif.req_dir    = ~v.dir;
                sif.req_amt    = v.amt + AMT_W'(1);
                sif.req_fill   = ~v.fill;
                sif.req_rotate = ~v.rot;
            end
            if (sif.sr_enable) begin
                en++;
                if (sif.sr_direction !== v.dir) dir_bad = 1'b1;
            end
        end while (!sif.rsp_valid && lat < 40);
        chk("latency", 32'(lat), 32'(v.amt) + 32'd2);
        chk("rsp_data", 32'(sif.rsp_data), 32'(v.exp));
        chk("shift_cycles", 32'(en), 32'(v.amt));
        chk("sr_direction", 32'(dir_bad), 32'd0);
        chk("req_ready_busy", 32'(sif.req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(sif.rsp_valid), 32'd1);
            chk("hold_data", 32'(sif.rsp_data), 32'(v.exp));
            chk("hold_req_ready", 32'(sif.req_ready), 32'd0);
        end
        sif.rsp_ready = 1'b1;
        @(negedge clk);
        sif.rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(sif.rsp_valid), 32'd0);
        chk("post_req_ready", 32'(sif.req_ready), 32'd1);
        chk("post_busy", 32'(sif.busy), 32'd0);
    endtask

    initial begin
        int vcount;
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{16'h00F1, 1'b1, 4'd4,  1'b0, 1'b0, 16'h0F10};
        vecs[1] = '{16'h8001, 1'b0, 4'd1,  1'b1, 1'b0, 16'hC000};
        vecs[2] = '{16'hA5A5, 1'b1, 4'd0,  1'b1, 1'b0, 16'hA5A5};
`ifdef SHIFT_ROTATE_EN
        vecs[3] = '{16'h8001, 1'b1, 4'd1,  1'b0, 1'b1, 16'h0003};
        vecs[7] = '{16'h1234, 1'b0, 4'd4,  1'b0, 1'b1, 16'h4123};
`else
        vecs[3] = '{16'h8001, 1'b1, 4'd1,  1'b0, 1'b1, 16'h0002};
        vecs[7] = '{16'h1234, 1'b0, 4'd4,  1'b0, 1'b1, 16'h0123};
`endif
        vecs[4] = '{16'h0001, 1'b1, 4'd15, 1'b0, 1'b0, 16'h8000};
        vecs[5] = '{16'h8000, 1'b0, 4'd15, 1'b0, 1'b0, 16'h0001};
        vecs[6] = '{16'h0F00, 1'b0, 4'd3,  1'b1, 1'b0, 16'hE1E0};
        vecs[8] = '{16'hFFFF, 1'b1, 4'd8,  1'b0, 1'b0, 16'hFF00};

        reset          = 1'b0;
        sif.req_valid  = 1'b0;
        sif.req_data   = '0;
        sif.req_dir    = 1'b0;
        sif.req_amt    = '0;
        sif.req_fill   = 1'b0;
        sif.req_rotate = 1'b0;
        sif.rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", 32'(sif.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(sif.rsp_valid), 32'd0);
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_sr_enable", 32'(sif.sr_enable), 32'd0);
        chk("rst_sr_in", 32'(sif.sr_in), 32'd0);
        chk("rst_sr_direction", 32'(sif.sr_direction), 32'd0);
        chk("rst_sr_I", 32'(sif.sr_I), 32'd0);

        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], 0);

        // Response back-pressure: result held, no new acceptance.
        run_vec(vecs[0], 3);

        // Reset during the 2nd SHIFT cycle aborts the request.
        sif.req_data  = 16'h1234;
        sif.req_dir   = 1'b1;
        sif.req_amt   = 4'd8;
        sif.req_fill  = 1'b0;
        sif.req_valid = 1'b1;
        @(negedge clk);
        sif.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_shift", 32'(sif.sr_enable), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", 32'(sif.req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(sif.rsp_valid), 32'd0);
        chk("abort_busy", 32'(sif.busy), 32'd0);
        chk("abort_sr_enable", 32'(sif.sr_enable), 32'd0);
        chk("abort_sr_out", 32'(sif.sr_out), 32'd0);
        reset = 1'b1;
        vcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (sif.rsp_valid) vcount++;
        end
        chk("abort_no_response", 32'(vcount), 32'd0);

        run_vec(vecs[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
